// File: rtl/drone_ppm_pkg.sv
// Shared types and helpers for the drone command PPM transmit path.
package drone_ppm_pkg;

    // Segment being driven on the PPM line.
    typedef enum logic [1:0] {
        StMark,
        StSpace,
        StEndMark,
        StSync
    } ppm_state_e;

    // Channel slot order within a frame.
    localparam int unsigned CH_ROLL  = 0;
    localparam int unsigned CH_PITCH = 1;
    localparam int unsigned CH_HOVER = 2;
    localparam int unsigned CH_YAW   = 3;
    localparam int unsigned CH_ARM   = 4;
    localparam int unsigned NUM_CH   = 5;
    localparam int unsigned CH_W     = 3;

    localparam logic [7:0] YAW_CENTER = 8'd128;

    // Slot length in us: min + 4*value, clamped to max. 12 bits hold 1000 + 1020 without overflow.
    function automatic logic [11:0] slot_len(input logic [7:0]  value,
                                             input logic [11:0] min_us,
                                             input logic [11:0] max_us);
        logic [11:0] raw;
        raw = min_us + {2'b00, value, 2'b00};
        return (raw > max_us) ? max_us : raw;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Prescaler: one-cycle tick every CLKS_PER_US clocks.
module us_tick_gen #(
    parameter int unsigned CLKS_PER_US = 27
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // Count 0..LAST and wrap on the tick.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ppm_encoder.sv
// Serialises roll/pitch/hover/arm commands into a fixed-period RC PPM frame.
module ppm_encoder
    import drone_ppm_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = 27,
    parameter int unsigned FRAME_US    = 22500,
    parameter int unsigned MARK_US     = 300,
    parameter int unsigned MIN_US      = 1000,
    parameter int unsigned MAX_US      = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] hover,
    input  logic [7:0] roll,
    input  logic [7:0] pitch,
    input  logic       on,
    output logic       ppm_out,
    output logic       frame_start,
    output logic       armed
);

    localparam logic [14:0] FRAME_LAST = 15'(FRAME_US - 1);
    localparam logic [11:0] MARK_LEN   = 12'(MARK_US);
    localparam logic [11:0] MIN_LEN    = 12'(MIN_US);
    localparam logic [11:0] MAX_LEN    = 12'(MAX_US);

    logic tick;

    ppm_state_e               state_q, state_d;
    logic [14:0]              fcnt_q, fcnt_d;
    logic [11:0]              seg_q, seg_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [NUM_CH-1:0][7:0]   chan_q, chan_d;
    logic                     armed_q, armed_d;
    logic                     ppm_q, ppm_d;
    logic                     fs_q, fs_d;

    logic [7:0]  cur_val;
    logic [11:0] space_len;
    logic        last_ch;
    logic        frame_edge;

    us_tick_gen #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // Select the latched value of the slot currently being sent.
    always_comb begin
        cur_val = 8'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                cur_val = chan_q[i];
            end
        end
    end

    assign space_len  = slot_len(cur_val, MIN_LEN, MAX_LEN) - MARK_LEN;
    assign last_ch    = (ch_q == CH_W'(NUM_CH - 1));
    // The frame counter alone decides the boundary, so a frame can never overrun.
    assign frame_edge = (fcnt_q == FRAME_LAST);

    // Next-state: segment sequencing, frame restart and input latching.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        seg_d   = seg_q;
        ch_d    = ch_q;
        chan_d  = chan_q;
        armed_d = armed_q;
        ppm_d   = ppm_q;
        fs_d    = 1'b0;

        if (tick) begin
            if (frame_edge) begin
                fcnt_d           = '0;
                state_d          = StMark;
                seg_d            = '0;
                ch_d             = '0;
                ppm_d            = 1'b0;
                fs_d             = 1'b1;
                armed_d          = on;
                chan_d[CH_ROLL]  = roll;
                chan_d[CH_PITCH] = pitch;
                chan_d[CH_HOVER] = on ? hover : 8'd0;
                chan_d[CH_YAW]   = YAW_CENTER;
                chan_d[CH_ARM]   = on ? 8'd255 : 8'd0;
            end else begin
                fcnt_d = fcnt_q + 15'd1;
                seg_d  = seg_q + 12'd1;
                case (state_q)
                    StMark: begin
                        if (seg_q == MARK_LEN - 12'd1) begin
                            seg_d   = '0;
                            state_d = StSpace;
                            ppm_d   = 1'b1;
                        end
                    end
                    StSpace: begin
                        if (seg_q == space_len - 12'd1) begin
                            seg_d = '0;
                            ppm_d = 1'b0;
                            if (last_ch) begin
                                state_d = StEndMark;
                            end else begin
                                ch_d    = ch_q + CH_W'(1);
                                state_d = StMark;
                            end
                        end
                    end
                    StEndMark: begin
                        if (seg_q == MARK_LEN - 12'd1) begin
                            seg_d   = '0;
                            state_d = StSync;
                            ppm_d   = 1'b1;
                        end
                    end
                    StSync: begin
                        seg_d = seg_q;
                    end
                    default: begin
                        state_d = StSync;
                        ppm_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    // State register; reset parks in SYNC one tick before a frame boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StSync;
            fcnt_q  <= FRAME_LAST;
            seg_q   <= '0;
            ch_q    <= '0;
            chan_q  <= '0;
            armed_q <= 1'b0;
            ppm_q   <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            seg_q   <= seg_d;
            ch_q    <= ch_d;
            chan_q  <= chan_d;
            armed_q <= armed_d;
            ppm_q   <= ppm_d;
            fs_q    <= fs_d;
        end
    end

    assign ppm_out     = ppm_q;
    assign frame_start = fs_q;
    assign armed       = armed_q;

endmodule

// File: doc/ppm_encoder.md
# ppm_encoder

Serialises the drone command bytes produced by `gest_rec` (hover, roll, pitch, on) into a standard RC PPM pulse train for the hobby transmitter's trainer port. The block is the transmit end of the gesture-to-drone command path. It latches one command set per frame and emits a fixed-period frame of five channel slots followed by a sync gap. All timing is counted in microsecond ticks derived from the system clock.

## Interface
- `CLKS_PER_US`, 27: clock cycles per 1 µs tick.
- `FRAME_US`, 22500: frame period in µs.
- `MARK_US`, 300: low marker width in µs.
- `MIN_US`, 1000: channel slot length for value 0.
- `MAX_US`, 2000: channel slot length clamp.

- `clock`  in  1  system clock; sole clock.
- `reset`  in  1  synchronous, active-high.
- `hover`  in  8  throttle command from gest_rec.
- `roll`  in  8  roll command.
- `pitch`  in  8  pitch command.
- `on`  in  1  arm request.
- `ppm_out`  out  1  PPM line; idle high, markers low.
- `frame_start`  out  1  one-cycle pulse when a frame begins.
- `armed`  out  1  latched `on` for the current frame.

## Operation
- Tick generator: counter 0..CLKS_PER_US-1; `tick` is asserted when the count equals CLKS_PER_US-1. All state and counters below advance only on `tick`.
- Channel order and values, latched at frame start:
  - ch0 = roll.
  - ch1 = pitch.
  - ch2 = on ? hover : 0.
  - ch3 = 128 (yaw centre).
  - ch4 = on ? 255 : 0.
- Slot length: len = MIN_US + 4·value, clamped to MAX_US, so values ≥ 250 give 2000.
  - Width rule: compute in 12 bits, compare, then clamp.
- Each slot is MARK (low, MARK_US ticks) then SPACE (high, len − MARK_US ticks).
- After ch4, END_MARK: low for MARK_US ticks.
- Then SYNC: high until the frame counter reaches FRAME_US.
  - Minimum sync = 22500 − 5·2000 − 300 = 12200 µs, so the frame never overruns.
- States: MARK → SPACE → (next channel MARK | END_MARK after ch4) → SYNC → MARK of ch0.
- Frame counter: 15 bits, counts ticks since frame start, wraps to 0 at FRAME_US−1.
- Input changes mid-frame have no effect until the next frame_start.

## Timing
- Reset values:
  - ppm_out = 1, frame_start = 0, armed = 0.
  - state = SYNC with the frame counter pending a frame start.
  - latches = 0, tick counter = 0.
- First tick after reset deasserts starts frame 0.
- On every frame-boundary tick, all of the following happen in the same registered cycle:
  - frame_start = 1 for exactly one clock.
  - ppm_out = 0.
  - inputs latched.
  - armed updated.
- ppm_out is registered. Each edge lands one clock after the tick that ends the previous segment.
- Successive frame_start pulses are exactly FRAME_US·CLKS_PER_US cycles apart.
- Reset mid-frame (any state): the next cycle shows ppm_out = 1 and frame_start = 0. The frame restarts from scratch and no partial slot is emitted.

## Structure
- Shared package `drone_ppm_pkg`:
  - State enum (MARK, SPACE, END_MARK, SYNC).
  - Channel index constants (CH_ROLL=0 … CH_ARM=4), NUM_CH=5, YAW_CENTER=128.
  - Slot-length helper function.
- Sub-module `us_tick_gen`: the parameterised prescaler producing `tick`.

## Test plan
Run all scenarios with CLKS_PER_US=1 unless noted.
- **Reset hold:** assert reset 10 cycles → ppm_out=1, frame_start=0, armed=0 throughout. Release → frame_start pulses on the first clock and ppm_out falls on the same cycle.
- **Slot widths:** roll=0, pitch=128, hover=255, on=1 →
  - low pulses of 300 cycles each.
  - marker-to-marker intervals 1000, 1512, 2000 (clamped), 1512, 2000.
  - sync high = 22500 − 8024 − 300 = 14176 cycles.
- **Disarm:** on=0, hover=200 → ch2 = 1000 and ch4 = 1000; armed=0 from that frame_start.
- **Mid-frame change:** change roll 0→255 during ch1 SPACE → the current frame keeps ch0 = 1000; the next frame shows ch0 = 2000.
- **Period:** run 3 frames → frame_start spacing exactly 22500 cycles. Repeat with CLKS_PER_US=27 → spacing 607500 cycles.
- **Reset mid-SPACE** of ch2 → ppm_out=1 one cycle later; after release, a fresh frame_start occurs with full 300-cycle marker.
